// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: reserved label value,
// default unit count, functional-unit indices and the round-robin wrap helper.
package cdb_arbiter_pkg;

    localparam int LABEL_NONE = 0;
    localparam int CDB_UNITS  = 3;

    typedef enum logic [1:0] {
        FU_PMF  = 2'd0,
        FU_MUL  = 2'd1,
        FU_LOAD = 2'd2
    } fu_e;

    // Next index in circular order 0..n-1.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit side of the common data bus: per-unit requests/results in,
// grants and the broadcast bus out.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int N  = CDB_UNITS,
    parameter int DW = 32,
    parameter int LW = 4
);
    logic [N-1:0]    require;
    logic [N*DW-1:0] dataIn;
    logic [N*LW-1:0] labelIn;
    logic [N-1:0]    requireAC;
    logic            cdbValid;
    logic [LW-1:0]   cdbLabel;
    logic [DW-1:0]   cdbData;

    modport master (
        output require, dataIn, labelIn,
        input  requireAC, cdbValid, cdbLabel, cdbData
    );

    modport slave (
        input  require, dataIn, labelIn,
        output requireAC, cdbValid, cdbLabel, cdbData
    );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: scans require upward from ptr with wrap and
// returns the one-hot grant plus binary winner index.
module cdb_arbiter_rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int N  = CDB_UNITS,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  require,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] win,
    output logic          any
);

    logic [PW-1:0] idx;
    logic          hit;

    // Walk N positions from ptr; the first requester seen takes the grant.
    always_comb begin
        grant = '0;
        win   = '0;
        any   = 1'b0;
        hit   = 1'b0;
        idx   = (int'(ptr) < N) ? ptr : '0;
        for (int i = 0; i < N; i++) begin
            hit        = !any && require[idx];
            grant[idx] = grant[idx] | hit;
            win        = hit ? idx : win;
            any        = any | hit;
            idx        = PW'(rr_next(int'(idx), N));
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one requesting unit per cycle round-robin and
// broadcasts its result and label on the CDB one cycle later.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N  = CDB_UNITS,
    parameter int DW = 32,
    parameter int LW = 4
) (
    input  logic          clk,
    input  logic          nRST,
    cdb_arbiter_if.slave  bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] data_arr  [N];
    logic [LW-1:0] label_arr [N];

    logic [N-1:0]  grant_s;
    logic [PW-1:0] win_s;
    logic          any_s;

    logic [PW-1:0] ptr_d,   ptr_q;
    logic          valid_d, valid_q;
    logic [LW-1:0] label_d, label_q;
    logic [DW-1:0] data_d,  data_q;

    for (genvar g = 0; g < N; g++) begin : g_slice
        assign data_arr[g]  = bus.dataIn[g*DW +: DW];
        assign label_arr[g] = bus.labelIn[g*LW +: LW];
    end

    cdb_arbiter_rr_picker #(.N(N), .PW(PW)) u_picker (
        .require (bus.require),
        .ptr     (ptr_q),
        .grant   (grant_s),
        .win     (win_s),
        .any     (any_s)
    );

    // Next broadcast and pointer; data is held over idle cycles, the label is not.
    always_comb begin
        ptr_d   = ptr_q;
        valid_d = 1'b0;
        label_d = LW'(LABEL_NONE);
        data_d  = data_q;
        if (any_s) begin
            ptr_d   = PW'(rr_next(int'(win_s), N));
            valid_d = 1'b1;
            label_d = label_arr[win_s];
            data_d  = data_arr[win_s];
        end else begin
            ptr_d   = ptr_q;
        end
    end

    // Pointer and broadcast register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            label_q <= '0;
            data_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            label_q <= label_d;
            data_q  <= data_d;
        end
    end

    // Grant is suppressed asynchronously while reset is held.
    always_comb begin
        if (nRST) begin
            bus.requireAC = grant_s;
        end else begin
            bus.requireAC = '0;
        end
        bus.cdbValid = valid_q;
        bus.cdbLabel = label_q;
        bus.cdbData  = data_q;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus responder for the Tomasulo core. Each functional unit (pmf ALU, multiplier, load unit, …) raises `require` while it holds a finished result. This block grants exactly one requester per cycle with `requireAC`, then broadcasts that requester's result and reservation-station label on the CDB one cycle later, for the reservation stations and register file to snoop. Arbitration is round-robin, so no unit starves.

## Interface
Parameters:
- `N`, 3: number of requesting functional units (2..8).
- `DW`, 32: result data width.
- `LW`, 4: label width. The label value 0 is reserved as "no producer".

Ports:
- `clk` input 1: system clock, rising edge.
- `nRST` input 1: reset, asynchronous, active-low.
- `require` input N: per-unit request. Level signal, held until the unit sees its grant.
- `dataIn` input N*DW: per-unit result, flattened. Unit i occupies bits [i*DW +: DW].
- `labelIn` input N*LW: per-unit label, flattened. Unit i occupies bits [i*LW +: LW].
- `requireAC` output N: one-hot or zero grant. Combinational within the request cycle.
- `cdbValid` output 1: a broadcast is on the bus this cycle.
- `cdbLabel` output LW: label being broadcast. Equals 0 when `cdbValid` is 0.
- `cdbData` output DW: data being broadcast. Holds its last value when `cdbValid` is 0.

## Operation
- Grant (combinational):
  - Scan `require` starting at index `ptr`, ascending, wrapping from N-1 to 0.
  - The first set bit wins and `requireAC[win]` is driven to 1; all other bits are 0.
  - If no request is set, `requireAC` is all zeros.
  - `requireAC` is forced to 0 while `nRST` is low.
- A request whose `labelIn` is 0 is still eligible and is granted normally. It is broadcast with `cdbValid=1` and `cdbLabel=0`; consumers ignore such a broadcast.
- Broadcast register, on the clock edge with a grant:
  - `cdbValid<=1`
  - `cdbLabel<=labelIn[win]`
  - `cdbData<=dataIn[win]`
- On a clock edge with no grant: `cdbValid<=0` and `cdbLabel<=0`; `cdbData` holds its value.
- Round-robin pointer `ptr` (width ceil(log2 N)):
  - On a grant edge, `ptr<=win+1`, wrapping to 0 when `win==N-1`.
  - With no grant, `ptr` is unchanged.
  - After a grant, the winner has the lowest priority for the next cycle.
- Requester contract:
  - A unit samples `requireAC` in the same cycle as its request and advances its own state on that edge. That edge may also carry a new request.
  - The arbiter keeps no per-unit state and does not detect a request that is dropped before it is granted.
- The state machine is implicit: `ptr` plus the broadcast register. There is no stall input; the bus accepts one broadcast every cycle.

## Timing
- Reset (async, on `nRST` low): `ptr=0`, `cdbValid=0`, `cdbLabel=0`, `cdbData=0`, `requireAC=0`.
- Latency from request to grant: 0 cycles (combinational).
- Latency from grant edge to broadcast: 1 cycle. Data sampled on edge k appears on the CDB during cycle k+1.
- Throughput: one broadcast per cycle. Back-to-back grants to different units give consecutive `cdbValid` cycles.
- A single unit requesting continuously is granted every cycle, because the wrap returns the search to it.
- All N units requesting simultaneously are served in order `ptr, ptr+1, …` over N cycles.
- Reset asserted mid-broadcast clears `cdbValid` immediately, without waiting for a clock edge; that result is lost. The requester is reset by the same `nRST`.
- `ptr` wrap: for `N=3`, sequence 0→1→2→0.

## Structure
- Shared constants in `head.v`:
  - `` `LabelNone `` (0).
  - `` `CDBUnits `` (default N).
  - Functional-unit index defines: `` `FUpmf=0 ``, `` `FUmul=1 ``, `` `FUload=2 ``.
- Sub-module `rrPicker`:
  - Purely combinational.
  - Inputs: `require`, `ptr`. Outputs: one-hot `grant` and binary `win`.
  - Reusable for reservation-station issue arbitration.
- Top level: flattened slicing, broadcast register, `ptr` update.

## Test plan
- Reset, then `require=3'b010`, `labelIn[1]=4'h5`, `dataIn[1]=32'h0000_00AA`:
  - `requireAC=3'b010` in the same cycle.
  - Next cycle: `cdbValid=1`, `cdbLabel=5`, `cdbData=AA`.
  - `ptr=2`.
- `require=3'b111` held 3 cycles from `ptr=0`:
  - Grants 001, 010, 100 in turn.
  - CDB carries labels of units 0, 1, 2 on consecutive cycles.
  - `ptr` returns to 0.
- `ptr=2`, `require=3'b011`: grant goes to unit 0 (wrap), then unit 1. No grant goes to an idle unit.
- Unit 0 requests continuously with labels 1, 2, 3 on successive cycles while the others are idle:
  - Granted every cycle.
  - CDB shows 1, 2, 3 with `cdbValid` high throughout.
- `require=0` for 2 cycles after a broadcast:
  - `cdbValid=0`, `cdbLabel=0`.
  - `cdbData` keeps its last value; `ptr` is unchanged.
- `nRST` pulsed low mid-cycle while `cdbValid=1`:
  - All outputs go to their reset values immediately.
  - `requireAC=0` while reset is low.
  - The first request after release is scanned from `ptr=0`.
